// File: rtl/eq_access_ctrl.sv
// ---------------------------------------------------------------------------
// eq_access_ctrl
// Shares one two-sub-queue event queue between NUM_WR event producers
// (inserts, round-robin arbitrated) and one consumer (extracts, fixed
// priority). Each granted transaction becomes a one-cycle command
// (eq_cs/eq_op) followed by a wait for the queue's matching busy flag.
//
// Optional feature (macro EQ_ACCESS_CAUSALITY_CHK_EN): inserts whose TIME
// field is older than the last extracted TIME are acknowledged but not
// issued, and err_causal pulses instead.
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   wr_req/wr_ev       per-producer insert request (level) and event slices
//   wr_ack             one-cycle pulse: producer i's event consumed
//   rd_req             consumer extract request (level)
//   rd_ev/rd_vld       extracted event and its one-cycle valid pulse
//   err_causal         one-cycle pulse on a rejected (non-causal) insert
//   busy               controller not in IDLE
//   eq_EV_in/eq_op/eq_cs   command bus to the event queue
//   eq_EV_out/eq_dv/eq_full/eq_empty/eq_busy_for_rd/eq_busy_for_wr
//                      status from the event queue
// ---------------------------------------------------------------------------
`ifndef INSERT_CMD
`define INSERT_CMD 1'b0
`endif
`ifndef EXTRACT_CMD
`define EXTRACT_CMD 1'b1
`endif

module eq_access_ctrl #(
    parameter int data_wd   = 32,
    parameter int hi        = 15,
    parameter int lo        = 0,
    parameter int NUM_WR    = 4,
    parameter int wr_idx_wd = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_WR-1:0]         wr_req,
    input  logic [NUM_WR*data_wd-1:0] wr_ev,
    output logic [NUM_WR-1:0]         wr_ack,
    input  logic                      rd_req,
    output logic [data_wd-1:0]        rd_ev,
    output logic                      rd_vld,
    output logic                      err_causal,
    output logic                      busy,
    output logic [data_wd-1:0]        eq_EV_in,
    output logic                      eq_op,
    output logic                      eq_cs,
    input  logic [data_wd-1:0]        eq_EV_out,
    input  logic                      eq_dv,
    input  logic                      eq_full,
    input  logic                      eq_empty,
    input  logic                      eq_busy_for_rd,
    input  logic                      eq_busy_for_wr
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    state_t               state_r;
    logic [wr_idx_wd-1:0] rr_ptr_r;
    logic                 reject_r;     // current ISSUE is a rejected insert
    logic                 rd_elig_s;
    logic                 wr_elig_s;
    logic                 sel_found_s;
    logic [wr_idx_wd-1:0] sel_idx_s;
    logic [wr_idx_wd-1:0] cand_s;
    logic [data_wd-1:0]   sel_ev_s;
    logic                 causal_bad_s;
    logic                 wait_busy_s;
`ifdef EQ_ACCESS_CAUSALITY_CHK_EN
    logic [hi-lo:0]       last_time_r;
`endif

    // Eligibility of the consumer and of the producer group this cycle.
    always_comb begin
        rd_elig_s = rd_req && eq_dv && !eq_empty && !eq_busy_for_rd;
        wr_elig_s = (|wr_req) && !eq_full && !eq_busy_for_wr;
    end

    // Round-robin pick: first requester at or after rr_ptr_r, cyclically.
    // NUM_WR is a power of two, so the pointer sum wraps naturally.
    always_comb begin
        sel_found_s = 1'b0;
        sel_idx_s   = {wr_idx_wd{1'b0}};
        cand_s      = rr_ptr_r;
        for (int k = 0; k < NUM_WR; k++) begin
            cand_s = rr_ptr_r + k[wr_idx_wd-1:0];
            if (!sel_found_s && wr_req[cand_s]) begin
                sel_found_s = 1'b1;
                sel_idx_s   = cand_s;
            end else begin
                sel_found_s = sel_found_s;
            end
        end
    end

    // Event slice of the selected producer.
    always_comb begin
        sel_ev_s = wr_ev[sel_idx_s*data_wd +: data_wd];
    end

    // Causality check of the selected insert against the last extracted time.
    always_comb begin
`ifdef EQ_ACCESS_CAUSALITY_CHK_EN
        causal_bad_s = (sel_ev_s[hi:lo] < last_time_r);
`else
        causal_bad_s = 1'b0;
`endif
    end

    // Busy flag matching the op that was last issued (eq_op holds it).
    always_comb begin
        if (eq_op == `EXTRACT_CMD) begin
            wait_busy_s = eq_busy_for_rd;
        end else begin
            wait_busy_s = eq_busy_for_wr;
        end
    end

    // Controller FSM; every output is registered and set one edge ahead
    // so that strobes are high exactly during the ISSUE cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            rr_ptr_r   <= {wr_idx_wd{1'b0}};
            reject_r   <= 1'b0;
            wr_ack     <= {NUM_WR{1'b0}};
            rd_ev      <= {data_wd{1'b0}};
            rd_vld     <= 1'b0;
            err_causal <= 1'b0;
            busy       <= 1'b0;
            eq_EV_in   <= {data_wd{1'b0}};
            eq_op      <= 1'b0;
            eq_cs      <= 1'b0;
`ifdef EQ_ACCESS_CAUSALITY_CHK_EN
            last_time_r <= {(hi-lo+1){1'b0}};
`endif
        end else begin
            eq_cs      <= 1'b0;
            wr_ack     <= {NUM_WR{1'b0}};
            rd_vld     <= 1'b0;
            err_causal <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (rd_elig_s) begin
                        rd_ev    <= eq_EV_out;
                        eq_op    <= `EXTRACT_CMD;
                        eq_cs    <= 1'b1;
                        rd_vld   <= 1'b1;
                        reject_r <= 1'b0;
                        busy     <= 1'b1;
                        state_r  <= ST_ISSUE;
                    end else if (wr_elig_s) begin
                        // A rejected insert is still acked so the producer moves on.
                        eq_EV_in   <= sel_ev_s;
                        eq_op      <= `INSERT_CMD;
                        eq_cs      <= !causal_bad_s;
                        err_causal <= causal_bad_s;
                        reject_r   <= causal_bad_s;
                        wr_ack     <= {{(NUM_WR-1){1'b0}}, 1'b1} << sel_idx_s;
                        rr_ptr_r   <= sel_idx_s + {{(wr_idx_wd-1){1'b0}}, 1'b1};
                        busy       <= 1'b1;
                        state_r    <= ST_ISSUE;
                    end else begin
                        busy    <= 1'b0;
                        state_r <= ST_IDLE;
                    end
                end
                ST_ISSUE: begin
`ifdef EQ_ACCESS_CAUSALITY_CHK_EN
                    if (rd_vld) begin
                        last_time_r <= rd_ev[hi:lo];
                    end
`endif
                    if (reject_r) begin
                        busy    <= 1'b0;
                        state_r <= ST_IDLE;
                    end else begin
                        busy    <= 1'b1;
                        state_r <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (wait_busy_s) begin
                        busy    <= 1'b1;
                        state_r <= ST_WAIT;
                    end else begin
                        busy    <= 1'b0;
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    busy    <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_eq_access_ctrl.sv
`ifndef INSERT_CMD
`define INSERT_CMD 1'b0
`endif
`ifndef EXTRACT_CMD
`define EXTRACT_CMD 1'b1
`endif

module tb_eq_access_ctrl;

    localparam int K_INS = 0;
    localparam int K_EXT = 1;
    localparam int K_REJ = 2;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   wr_req;
    logic [127:0] wr_ev;
    logic [3:0]   wr_ack;
    logic         rd_req;
    logic [31:0]  rd_ev;
    logic         rd_vld;
    logic         err_causal;
    logic         busy;
    logic [31:0]  eq_EV_in;
    logic         eq_op;
    logic         eq_cs;
    logic [31:0]  eq_EV_out;
    logic         eq_dv;
    logic         eq_full;
    logic         eq_empty;
    logic         eq_busy_for_rd;
    logic         eq_busy_for_wr;

    typedef struct {
        int          kind;
        logic [31:0] data;
        int          idx;
    } exp_t;

    exp_t exp_q[$];
    exp_t e_m;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   last_cs = -100;
    logic [6:0] exp_ctrl;

    always #5 clk = ~clk;

    eq_access_ctrl dut (
        .clk(clk), .rst(rst), .wr_req(wr_req), .wr_ev(wr_ev), .wr_ack(wr_ack),
        .rd_req(rd_req), .rd_ev(rd_ev), .rd_vld(rd_vld), .err_causal(err_causal),
        .busy(busy), .eq_EV_in(eq_EV_in), .eq_op(eq_op), .eq_cs(eq_cs),
        .eq_EV_out(eq_EV_out), .eq_dv(eq_dv), .eq_full(eq_full), .eq_empty(eq_empty),
        .eq_busy_for_rd(eq_busy_for_rd), .eq_busy_for_wr(eq_busy_for_wr)
    );

    // Scoreboard: every command/ack/valid/error event pops one expectation.
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (!rst && (eq_cs || (wr_ack != 4'b0000) || rd_vld || err_causal)) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected cs=%0b ack=%b rd_vld=%0b err=%0b required=no_event",
                         eq_cs, wr_ack, rd_vld, err_causal);
            end else begin
                e_m = exp_q.pop_front();
                if (e_m.kind == K_INS)      exp_ctrl = {1'b1, 4'b0001 << e_m.idx, 1'b0, 1'b0};
                else if (e_m.kind == K_EXT) exp_ctrl = {1'b1, 4'b0000, 1'b1, 1'b0};
                else                        exp_ctrl = {1'b0, 4'b0001 << e_m.idx, 1'b0, 1'b1};
                checks++;
                if ({eq_cs, wr_ack, rd_vld, err_causal} !== exp_ctrl) begin
                    errors++;
                    $display("FAIL sb_ctrl {cs,ack,rd_vld,err} got=%b required=%b",
                             {eq_cs, wr_ack, rd_vld, err_causal}, exp_ctrl);
                end
                if (e_m.kind == K_INS) begin
                    checks++;
                    if ({eq_op, eq_EV_in} !== {`INSERT_CMD, e_m.data}) begin
                        errors++;
                        $display("FAIL sb_insert op/data got=%0b/%h required=%0b/%h",
                                 eq_op, eq_EV_in, `INSERT_CMD, e_m.data);
                    end
                end else if (e_m.kind == K_EXT) begin
                    checks++;
                    if ({eq_op, rd_ev} !== {`EXTRACT_CMD, e_m.data}) begin
                        errors++;
                        $display("FAIL sb_extract op/data got=%0b/%h required=%0b/%h",
                                 eq_op, rd_ev, `EXTRACT_CMD, e_m.data);
                    end
                end
            end
            if (eq_cs) begin
                checks++;
                if (cyc - last_cs < 3) begin
                    errors++;
                    $display("FAIL sb_spacing gap=%0d required>=3", cyc - last_cs);
                end
                last_cs = cyc;
            end
        end
    end

    task automatic set_ev(input int i, input logic [31:0] v);
        wr_ev[32*i +: 32] = v;
    endtask

    task automatic push(input int kind, input logic [31:0] data, input int idx);
        exp_t e;
        e.kind = kind;
        e.data = data;
        e.idx  = idx;
        exp_q.push_back(e);
    endtask

    task automatic test_reset;
        @(negedge clk); #1;
        checks++;
        if ({eq_cs, eq_op, wr_ack, rd_vld, err_causal, busy} !== 10'b0) begin
            errors++;
            $display("FAIL reset_ctrl got=%b required=0", {eq_cs, eq_op, wr_ack, rd_vld, err_causal, busy});
        end
        checks++;
        if ({rd_ev, eq_EV_in} !== 64'b0) begin
            errors++;
            $display("FAIL reset_data rd_ev=%h eq_EV_in=%h required=0", rd_ev, eq_EV_in);
        end
        push(K_EXT, 32'h5A5A_0000, 0);
        push(K_INS, wr_ev[127:96], 3);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk); #1;
        checks++;
        if (eq_cs !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_cs got=%0b required=0", eq_cs);
        end
        @(negedge clk); #1;
        checks++;
        if (rd_vld !== 1'b1) begin
            errors++;
            $display("FAIL reset_first_latency rd_vld got=%0b required=1", rd_vld);
        end
        rd_req = 1'b0;
        for (int n = 0; n < 20 && exp_q.size() != 0; n++) begin
            @(negedge clk); #1;
            if (wr_ack[3]) wr_req = 4'b0000;
        end
        wr_req = 4'b0000;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL reset_drain pending=%0d required=0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_round_robin;
        int acks = 0;
        for (int i = 0; i < 4; i++) set_ev(i, 32'hA000_0100 + i);
        for (int i = 0; i < 5; i++) push(K_INS, 32'hA000_0100 + (i % 4), i % 4);
        wr_req = 4'b1111;
        for (int n = 0; n < 40 && (exp_q.size() != 0 || acks < 5); n++) begin
            @(negedge clk); #1;
            if (wr_ack != 4'b0000) acks++;
            if (acks >= 5) wr_req = 4'b0000;
        end
        wr_req = 4'b0000;
        checks++;
        if (exp_q.size() != 0 || acks != 5) begin
            errors++;
            $display("FAIL rr_drain pending=%0d acks=%0d required=0/5", exp_q.size(), acks);
            exp_q.delete();
        end
    endtask

    task automatic test_busy_stretch;
        bit got = 0;
        set_ev(1, 32'hB100_0201);
        set_ev(2, 32'hB200_0202);
        push(K_INS, 32'hB100_0201, 1);
        push(K_INS, 32'hB200_0202, 2);
        wr_req = 4'b0110;
        for (int n = 0; n < 10 && !got; n++) begin
            @(negedge clk); #1;
            if (wr_ack[1]) got = 1;
        end
        wr_req[1] = 1'b0;
        eq_busy_for_wr = 1'b1;
        for (int n = 0; n < 4; n++) begin
            @(negedge clk); #1;
            checks++;
            if ({busy, eq_cs} !== 2'b10) begin
                errors++;
                $display("FAIL busy_stretch cyc%0d {busy,cs} got=%b required=10", n, {busy, eq_cs});
            end
        end
        eq_busy_for_wr = 1'b0;
        got = 0;
        for (int n = 0; n < 5 && !got; n++) begin
            @(negedge clk); #1;
            if (wr_ack[2]) got = 1;
        end
        wr_req = 4'b0000;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL busy_drain pending=%0d required=0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_boundaries;
        int lat = 0;
        bit got = 0;
        set_ev(0, 32'hC000_0300);
        push(K_INS, 32'hC000_0300, 0);
        eq_full = 1'b1;
        wr_req  = 4'b0001;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk); #1;
            checks++;
            if ({eq_cs, wr_ack} !== 5'b0) begin
                errors++;
                $display("FAIL full_stall {cs,ack} got=%b required=0", {eq_cs, wr_ack});
            end
        end
        eq_full = 1'b0;
        for (int n = 0; n < 4 && !got; n++) begin
            @(negedge clk); #1;
            lat++;
            if (wr_ack[0]) got = 1;
        end
        wr_req = 4'b0000;
        checks++;
        if (!got || lat > 2) begin
            errors++;
            $display("FAIL full_release ack_latency got=%0d acked=%0b required<=2", lat, got);
        end
        repeat (3) @(negedge clk);
        #1;
        eq_empty = 1'b1;
        eq_dv    = 1'b0;
        rd_req   = 1'b1;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk); #1;
            checks++;
            if ({rd_vld, eq_cs} !== 2'b00) begin
                errors++;
                $display("FAIL empty_stall {rd_vld,cs} got=%b required=00", {rd_vld, eq_cs});
            end
        end
        rd_req = 1'b0;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL bound_drain pending=%0d required=0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_priority;
        eq_EV_out = 32'h1234_0005;
        eq_dv     = 1'b1;
        eq_empty  = 1'b0;
        set_ev(2, 32'hD000_0400);
        push(K_EXT, 32'h1234_0005, 0);
        push(K_INS, 32'hD000_0400, 2);
        rd_req = 1'b1;
        wr_req = 4'b0100;
        for (int n = 0; n < 20 && exp_q.size() != 0; n++) begin
            @(negedge clk); #1;
            if (rd_vld) rd_req = 1'b0;
            if (wr_ack[2]) wr_req = 4'b0000;
        end
        rd_req = 1'b0;
        wr_req = 4'b0000;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL prio_drain pending=%0d required=0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_causality;
        eq_EV_out = 32'h7700_0014;
        push(K_EXT, 32'h7700_0014, 0);
        rd_req = 1'b1;
        for (int n = 0; n < 10 && exp_q.size() != 0; n++) begin
            @(negedge clk); #1;
            if (rd_vld) rd_req = 1'b0;
        end
        rd_req = 1'b0;
        set_ev(1, 32'hE000_0013);
`ifdef EQ_ACCESS_CAUSALITY_CHK_EN
        push(K_REJ, 32'hE000_0013, 1);
`else
        push(K_INS, 32'hE000_0013, 1);
`endif
        for (int pass = 0; pass < 2; pass++) begin
            wr_req = 4'b0010;
            for (int n = 0; n < 12 && exp_q.size() != 0; n++) begin
                @(negedge clk); #1;
                if (wr_ack[1]) wr_req = 4'b0000;
            end
            wr_req = 4'b0000;
            checks++;
            if (exp_q.size() != 0) begin
                errors++;
                $display("FAIL causal_drain pass%0d pending=%0d required=0", pass, exp_q.size());
                exp_q.delete();
            end
            set_ev(1, 32'hE000_0014);
            if (pass == 0) push(K_INS, 32'hE000_0014, 1);
            repeat (3) @(negedge clk);
            #1;
        end
    endtask

    initial begin
        rst            = 1'b1;
        wr_req         = 4'b1000;
        wr_ev          = 128'h0;
        set_ev(3, 32'h3300_0050);
        rd_req         = 1'b1;
        eq_EV_out      = 32'h5A5A_0000;
        eq_dv          = 1'b1;
        eq_empty       = 1'b0;
        eq_full        = 1'b0;
        eq_busy_for_rd = 1'b0;
        eq_busy_for_wr = 1'b0;
        test_reset();
        test_round_robin();
        test_busy_stretch();
        test_boundaries();
        test_priority();
        test_causality();
        repeat (4) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/eq_access_ctrl.md
# eq_access_ctrl

Access controller that sequences and shares one two-sub-queue event queue between `NUM_WR` event producers and one event consumer. Each transaction becomes a single-cycle command (`cs`, `op`) to the queue, and the controller then waits out the queue's busy window. Inserts are round-robin arbitrated; extract requests have priority. The block sits between the simulation engine's evaluation units (producers), the time-advance unit (consumer) and the event queue.

## Interface
- `data_wd`, 32: event entry width.
- `hi`, 15: TIME field high bit inside an entry.
- `lo`, 0: TIME field low bit inside an entry.
- `NUM_WR`, 4: number of insert requesters.
- `wr_idx_wd`, 2: log2(`NUM_WR`), width of the round-robin pointer.

Ports:
- `clk`  in  1  clock; everything is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `wr_req`  in  NUM_WR  per-producer insert request, level, held until acked.
- `wr_ev`  in  NUM_WR*data_wd  producer events; producer i uses slice i.
- `wr_ack`  out  NUM_WR  one-cycle pulse: event i consumed.
- `rd_req`  in  1  consumer extract request, level.
- `rd_ev`  out  data_wd  extracted event; valid while `rd_vld`.
- `rd_vld`  out  1  one-cycle pulse with extracted event.
- `err_causal`  out  1  one-cycle pulse, causality violation (see Configuration).
- `busy`  out  1  controller not in IDLE.
- `eq_EV_in`  out  data_wd  queue insert data.
- `eq_op`  out  1  `` `INSERT_CMD `` / `` `EXTRACT_CMD ``.
- `eq_cs`  out  1  queue command strobe.
- `eq_EV_out`  in  data_wd  queue head event (peek).
- `eq_dv`  in  1  `eq_EV_out` valid.
- `eq_full`  in  1  queue full.
- `eq_empty`  in  1  queue empty.
- `eq_busy_for_rd`  in  1  queue cannot accept an extract.
- `eq_busy_for_wr`  in  1  queue cannot accept an insert.

## Operation
- **Reset values.** All outputs are registered. Reset drives every output to 0, the state to IDLE, the RR pointer to 0 and `last_time` to 0.
- **States.** IDLE, ISSUE, WAIT.
- **Eligibility.**
  - Read: `rd_req && eq_dv && !eq_empty && !eq_busy_for_rd`.
  - Write: any `wr_req` set, `!eq_full && !eq_busy_for_wr`.
- **IDLE.**
  - If read-eligible, go to ISSUE with op = EXTRACT and capture `eq_EV_out` into `rd_ev`.
  - Otherwise, if write-eligible, pick the first requester at or after the RR pointer (cyclic). Latch its event into `eq_EV_in`, op = INSERT, go to ISSUE.
  - Otherwise stay in IDLE.
- **ISSUE (exactly 1 cycle).**
  - `eq_cs` = 1.
  - Extract: `rd_vld` = 1 and `last_time` ← `rd_ev[hi:lo]`.
  - Insert: `wr_ack[i]` = 1 and the RR pointer ← i+1 mod NUM_WR.
  - Next state is WAIT.
- **WAIT.** Stay while the busy flag matching the issued op is high. Go to IDLE when it is low; at least 1 cycle is spent in WAIT.
- **Priority.** Read has fixed priority over write; a pending insert waits while reads keep winning.
- **Full/empty.** With the queue full, writers stall with no ack; `eq_cs` is never raised for an insert. With the queue empty or `!eq_dv`, `rd_req` stalls.
- **Bus idle values.** `eq_op` and `eq_EV_in` hold their last value outside ISSUE; only `eq_cs` qualifies them.
- **Request drop.** A requester dropping its request before it is granted is legal. A request dropped after the IDLE decision still completes.
- **Reset mid-operation.** The controller returns to IDLE next cycle. An in-flight ack or `rd_vld` is suppressed if `rst` coincides with ISSUE; the queue is reset by the same `rst`.

## Timing
- Request sampled eligible at edge t → `eq_cs`/ack/`rd_vld` high in cycle t+1.
- WAIT starts at t+2. IDLE is reached at t+3 at the earliest, so the next command is at t+4 at the earliest.
- Maximum command rate is one per 3 cycles, plus queue busy cycles.
- `rd_ev` is stable from the `rd_vld` cycle until the next extract.
- At most one `wr_ack` bit is high in any cycle. `wr_ack` and `rd_vld` are never high together.

## Configuration
- Macro `EQ_ACCESS_CAUSALITY_CHK_EN`.
- **Defined:** in IDLE, a selected insert with `wr_ev[hi:lo]` < `last_time` is rejected.
  - The ISSUE cycle pulses `wr_ack[i]` and `err_causal` with `eq_cs` = 0.
  - The next state is IDLE, not WAIT.
  - Equal time is accepted.
- **Undefined:** no comparison is made, `err_causal` is tied to 0 and all inserts are issued.

## Test plan
- **Reset:** assert `rst` with requests active → all outputs 0 next cycle; no `eq_cs` until 1 cycle after `rst` falls.
- **Round-robin:** `wr_req`=4'b1111 held, queue never busy → acks in order 0,1,2,3,0; each `eq_cs` carries the matching `wr_ev` slice with op=INSERT, commands ≥3 cycles apart.
- **Priority:** `rd_req` and `wr_req[2]` raised together with head time 5 → `rd_vld` with time 5 first, then `wr_ack[2]` in a later command.
- **Boundaries:**
  - `eq_full`=1 with `wr_req`=4'b0001 → no ack and no `eq_cs`; `eq_full` dropped → ack within 2 cycles.
  - Empty queue with `rd_req` → no `rd_vld`.
- **Busy stretch:** `eq_busy_for_wr` held 4 cycles after an insert → controller stays in WAIT, `busy`=1 throughout, next command only after busy drops.
- **Causality (macro on):** extract an event with time 20, then insert time 19 → `wr_ack` + `err_causal`, no `eq_cs`. Insert time 20 → issued normally.
